// File: rtl/riscv32_soc_pkg.sv
// Shared SoC constants: arbiter state encoding, bus width defaults, one-hot grant codes.
package riscv32_soc_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;
endpackage

// File: rtl/riscv32_ram_arbiter_rr_pick2.sv
// Two-way picker: lone requester wins; on a tie the master that did not win last time
// (or M0 when fixed_prio is set) takes the grant.
module rr_pick2
  import riscv32_soc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,  // 1 = M1 won last
  input  logic       fixed_prio,
  output logic [1:0] grant
);
  always_comb begin
    grant = req;
    if (req == 2'b11)
      grant = (fixed_prio || last_grant) ? GNT_M0 : GNT_M1;
  end
endmodule

// File: rtl/riscv32_ram_arbiter.sv
// Serialises one-word transactions from M0 (CPU) and M1 (DMA) onto a single-port RAM:
// IDLE grants and latches the request, ACCESS drives the RAM, DONE pulses the winner's ACK.
module riscv32_ram_arbiter
  import riscv32_soc_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iM0_REQ,
  input  logic          iM0_WR,
  input  logic [AW-1:0] iM0_ADDR,
  input  logic [DW-1:0] iM0_WDATA,
  output logic [DW-1:0] oM0_RDATA,
  output logic          oM0_ACK,
  input  logic          iM1_REQ,
  input  logic          iM1_WR,
  input  logic [AW-1:0] iM1_ADDR,
  input  logic [DW-1:0] iM1_WDATA,
  output logic [DW-1:0] oM1_RDATA,
  output logic          oM1_ACK,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [DW-1:0] oRAM_DATA,
  input  logic [DW-1:0] iRAM_DATA,
  output logic [1:0]    oGRANT
);
  arb_state_t    state, state_nx;
  logic [1:0]    pick, gnt;
  logic          last_m1, wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0, rdata1;
  logic          access, done;

  rr_pick2 u_pick (
    .req        ({iM1_REQ, iM0_REQ}),
    .last_grant (last_m1),
    .fixed_prio (FIXED_PRIO),
    .grant      (pick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pick) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      gnt     <= GNT_NONE;
      last_m1 <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (|pick) begin
          gnt     <= pick;
          last_m1 <= pick[1];
          wr_q    <= pick[1] ? iM1_WR    : iM0_WR;
          addr_q  <= pick[1] ? iM1_ADDR  : iM0_ADDR;
          wdata_q <= pick[1] ? iM1_WDATA : iM0_WDATA;
        end
        ACCESS: if (!wr_q) begin
          if (gnt[0]) rdata0 <= iRAM_DATA;
          if (gnt[1]) rdata1 <= iRAM_DATA;
        end
        DONE:    gnt <= GNT_NONE;
        default: gnt <= GNT_NONE;
      endcase
    end
  end

  // Strobes are gated by reset so a write caught in ACCESS never reaches the RAM edge.
  assign access    = (state == ACCESS) && !iRST;
  assign done      = (state == DONE) && !iRST;
  assign oRAM_CE   = access;
  assign oRAM_RD   = access && !wr_q;
  assign oRAM_WR   = access && wr_q;
  assign oRAM_ADDR = addr_q;
  assign oRAM_DATA = wdata_q;
  assign oM0_ACK   = done && gnt[0];
  assign oM1_ACK   = done && gnt[1];
  assign oM0_RDATA = rdata0;
  assign oM1_RDATA = rdata1;
  assign oGRANT    = gnt;
endmodule

// File: tb/tb_riscv32_ram_arbiter.sv
// Directed bench: round-robin instance (a) fully checked, fixed-priority instance (b)
// checked on the dual-request sequence; each instance has its own RAM model.
module tb_riscv32_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  logic [31:0] a_rd0, a_rd1, a_rdat, a_ramq;
  logic        a_ack0, a_ack1, a_ce, a_rd, a_wr;
  logic [7:0]  a_addr;
  logic [1:0]  a_gnt;
  logic [31:0] b_rd0, b_rd1, b_rdat, b_ramq;
  logic        b_ack0, b_ack1, b_ce, b_rd, b_wr;
  logic [7:0]  b_addr;
  logic [1:0]  b_gnt;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign a_ramq = mem_a[a_addr];
  assign b_ramq = mem_b[b_addr];

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (a_wr) mem_a[a_addr] <= a_rdat;
  end
  always @(posedge clk) begin
    if (pre_we) mem_b[pre_addr] <= pre_data;
    else if (b_wr) mem_b[b_addr] <= b_rdat;
  end

  riscv32_ram_arbiter #(.AW(8), .DW(32), .FIXED_PRIO(1'b0)) dut_a (
    .iCLK(clk), .iRST(rst),
    .iM0_REQ(m0_req), .iM0_WR(m0_wr), .iM0_ADDR(m0_addr), .iM0_WDATA(m0_wdata),
    .oM0_RDATA(a_rd0), .oM0_ACK(a_ack0),
    .iM1_REQ(m1_req), .iM1_WR(m1_wr), .iM1_ADDR(m1_addr), .iM1_WDATA(m1_wdata),
    .oM1_RDATA(a_rd1), .oM1_ACK(a_ack1),
    .oRAM_CE(a_ce), .oRAM_RD(a_rd), .oRAM_WR(a_wr), .oRAM_ADDR(a_addr),
    .oRAM_DATA(a_rdat), .iRAM_DATA(a_ramq), .oGRANT(a_gnt)
  );

  riscv32_ram_arbiter #(.AW(8), .DW(32), .FIXED_PRIO(1'b1)) dut_b (
    .iCLK(clk), .iRST(rst),
    .iM0_REQ(m0_req), .iM0_WR(m0_wr), .iM0_ADDR(m0_addr), .iM0_WDATA(m0_wdata),
    .oM0_RDATA(b_rd0), .oM0_ACK(b_ack0),
    .iM1_REQ(m1_req), .iM1_WR(m1_wr), .iM1_ADDR(m1_addr), .iM1_WDATA(m1_wdata),
    .oM1_RDATA(b_rd1), .oM1_ACK(b_ack1),
    .oRAM_CE(b_ce), .oRAM_RD(b_rd), .oRAM_WR(b_wr), .oRAM_ADDR(b_addr),
    .oRAM_DATA(b_rdat), .iRAM_DATA(b_ramq), .oGRANT(b_gnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEADBEEF;
    tick();
    pre_addr = 8'h20; pre_data = 32'h0BADF00D;
    tick();
    pre_addr = 8'h30; pre_data = 32'hCAFEF00D;
    tick();
    pre_we = 1'b0;
    chk("rst_ce", a_ce, 0);     chk("rst_rd", a_rd, 0);    chk("rst_wr", a_wr, 0);
    chk("rst_addr", a_addr, 0); chk("rst_data", a_rdat, 0);
    chk("rst_ack0", a_ack0, 0); chk("rst_ack1", a_ack1, 0);
    chk("rst_rdata0", a_rd0, 0); chk("rst_rdata1", a_rd1, 0); chk("rst_gnt", a_gnt, 0);
    rst = 1'b0;
    tick();
    chk("idle_ce", a_ce, 0);

    // M0 read 0x10
    m0_req = 1; m0_wr = 0; m0_addr = 8'h10;
    tick();
    chk("t1_ce", a_ce, 1); chk("t1_rd", a_rd, 1); chk("t1_wr", a_wr, 0);
    chk("t1_addr", a_addr, 8'h10); chk("t1_gnt", a_gnt, 2'b01); chk("t1_ack0_early", a_ack0, 0);
    tick();
    chk("t1_ack0", a_ack0, 1); chk("t1_ack1", a_ack1, 0);
    chk("t1_rdata0", a_rd0, 32'hDEADBEEF); chk("t1_ce_done", a_ce, 0);
    chk("t1_addr_hold", a_addr, 8'h10);
    m0_req = 0;
    tick();
    chk("t1_ack0_off", a_ack0, 0); chk("t1_gnt_clr", a_gnt, 0);
    tick();
    chk("t1_idle_ce", a_ce, 0);

    // M1 read 0x10 so its RDATA holds a known value
    m1_req = 1; m1_wr = 0; m1_addr = 8'h10;
    tick();
    chk("t2_gnt", a_gnt, 2'b10);
    tick();
    chk("t2_ack1", a_ack1, 1); chk("t2_ack0", a_ack0, 0); chk("t2_rdata1", a_rd1, 32'hDEADBEEF);
    m1_req = 0;
    tick();

    // M1 write 0x20 = 0x12345678
    m1_req = 1; m1_wr = 1; m1_addr = 8'h20; m1_wdata = 32'h12345678;
    tick();
    chk("t3_wr", a_wr, 1); chk("t3_rd", a_rd, 0); chk("t3_data", a_rdat, 32'h12345678);
    chk("t3_addr", a_addr, 8'h20);
    tick();
    chk("t3_ack1", a_ack1, 1); chk("t3_wr_off", a_wr, 0);
    chk("t3_rdata1_kept", a_rd1, 32'hDEADBEEF); chk("t3_mem", mem_a[8'h20], 32'h12345678);
    m1_req = 0; m1_wr = 0;
    tick();

    // M0 read back 0x20
    m0_req = 1; m0_wr = 0; m0_addr = 8'h20;
    tick();
    tick();
    chk("t4_ack0", a_ack0, 1); chk("t4_rdata0", a_rd0, 32'h12345678);
    chk("t4_rdata1", a_rd1, 32'hDEADBEEF);
    m0_req = 0;
    tick();

    // M1 write 0x30 aborted by reset during ACCESS
    m1_req = 1; m1_wr = 1; m1_addr = 8'h30; m1_wdata = 32'h55555555;
    tick();
    chk("t5_wr", a_wr, 1);
    rst = 1; m1_req = 0;
    #1;
    chk("t5_wr_gated", a_wr, 0);
    tick();
    chk("t5_ce", a_ce, 0); chk("t5_wr0", a_wr, 0); chk("t5_addr", a_addr, 0);
    chk("t5_data", a_rdat, 0); chk("t5_ack1", a_ack1, 0); chk("t5_gnt", a_gnt, 0);
    chk("t5_rdata0", a_rd0, 0); chk("t5_rdata1", a_rd1, 0);
    rst = 0; m1_wr = 0;
    tick();
    chk("t5_ack1_after", a_ack1, 0); chk("t5_ce_after", a_ce, 0);
    chk("t5_mem", mem_a[8'h30], 32'hCAFEF00D);

    // Continuous dual requests: alternate in (a), M0 always in (b)
    m0_req = 1; m0_wr = 0; m0_addr = 8'h10;
    m1_req = 1; m1_wr = 0; m1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dual_gnt_rr", a_gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
      chk("dual_gnt_fp", b_gnt, 2'b01);
      tick();
      chk("dual_ack0_rr", a_ack0, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("dual_ack1_rr", a_ack1, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk("dual_ack0_fp", b_ack0, 1);
      chk("dual_ack1_fp", b_ack1, 0);
      if (i % 2 == 1) chk("dual_rdata1_rr", a_rd1, 32'h12345678);
      tick();
      chk("dual_idle_rr", a_gnt, 0);
    end
    m0_req = 0; m1_req = 0;
    tick();
    chk("dual_end_ce", a_ce, 0); chk("dual_end_gnt", a_gnt, 0);

    // M0 drops REQ during ACCESS
    m0_req = 1; m0_wr = 0; m0_addr = 8'h30;
    tick();
    chk("t7_rd", a_rd, 1);
    m0_req = 0;
    tick();
    chk("t7_ack0", a_ack0, 1); chk("t7_rdata0", a_rd0, 32'hCAFEF00D);
    tick();
    chk("t7_ack0_off", a_ack0, 0); chk("t7_gnt", a_gnt, 0);
    tick();
    chk("t7_ce", a_ce, 0); chk("t7_ack0_quiet", a_ack0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
